// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@72 raster timing shared by the timing generator
// and the console top level (which can use SCREEN_WIDTH/HEIGHT from here).
package vga_pkg;

    localparam int unsigned DEF_H_VISIBLE = 800;
    localparam int unsigned DEF_H_FRONT   = 56;
    localparam int unsigned DEF_H_SYNC    = 120;
    localparam int unsigned DEF_H_BACK    = 64;
    localparam int unsigned DEF_V_VISIBLE = 600;
    localparam int unsigned DEF_V_FRONT   = 37;
    localparam int unsigned DEF_V_SYNC    = 6;
    localparam int unsigned DEF_V_BACK    = 23;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;   // 1040
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;   // 666

    // 800x600@72 uses positive sync pulses.
    localparam bit          DEF_SYNC_POL = 1'b1;
    localparam int unsigned DEF_CLK_DIV  = 2;

    localparam int unsigned H_COORD_W = 11;
    localparam int unsigned V_COORD_W = 10;

    localparam int unsigned SCREEN_WIDTH  = DEF_H_VISIBLE;
    localparam int unsigned SCREEN_HEIGHT = DEF_V_VISIBLE;

    // Drive a sync pin: active level when asserted, the opposite otherwise.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Wrapping counter with enable plus
// combinational decode of last-value, visible and sync-window flags.
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 1040,
    parameter int unsigned VISIBLE    = 800,
    parameter int unsigned SYNC_START = 856,
    parameter int unsigned SYNC_LEN   = 120,
    parameter int unsigned W          = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         vis_o,
    output logic         sync_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Flags are decoded in 32 bits so a window ending exactly at TOTAL
    // cannot alias through a truncated constant.
    assign wrap_o = (32'(cnt_q) == TOTAL - 1);
    assign vis_o  = (32'(cnt_q) < VISIBLE);
    assign sync_o = (32'(cnt_q) >= SYNC_START) &&
                    (32'(cnt_q) < SYNC_START + SYNC_LEN);
    assign cnt_o  = cnt_q;

    // Next count: advance on enable, return to 0 after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing (coords, display enable, syncs, frame start).
// Optional macro VGA_PIX_DIV_EN: divide clk by CLK_DIV to make the pixel
// tick; without it every clk is a pixel and CLK_DIV is only range-checked.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          SYNC_POL  = DEF_SYNC_POL,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 arst_n,
    output logic [H_COORD_W-1:0] o_h_coord,
    output logic [V_COORD_W-1:0] o_v_coord,
    output logic                 o_disp_enbl,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    // Elaboration-time parameter sanity.
    if (H_TOTAL > 2048 || H_TOTAL < 2) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL out of range 2..2048");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 2) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL out of range 2..1024");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic tick;

`ifdef VGA_PIX_DIV_EN
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;

    // Pixel tick on the last clk of each CLK_DIV group; CLK_DIV=1 ticks always.
    always_comb begin
        tick  = (32'(div_q) == CLK_DIV - 1);
        div_d = tick ? '0 : div_q + DW'(1);
    end

    // Clock divider register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_vis, h_sync;
    logic          v_wrap_unused, v_vis, v_sync;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .W          (HW)
    ) u_h_axis (
        .clk    (clk),
        .arst_n (arst_n),
        .en_i   (tick),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap),
        .vis_o  (h_vis),
        .sync_o (h_sync)
    );

    // Line counter steps only when the pixel counter leaves its last column,
    // so it wraps only when both axes are at their last values.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .W          (VW)
    ) u_v_axis (
        .clk    (clk),
        .arst_n (arst_n),
        .en_i   (tick & h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap_unused),
        .vis_o  (v_vis),
        .sync_o (v_sync)
    );

    logic [H_COORD_W-1:0] h_coord_q, h_coord_d;
    logic [V_COORD_W-1:0] v_coord_q, v_coord_d;
    logic                 disp_q, disp_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 fs_q, fs_d;

    // Output decode: load on a tick, hold otherwise; frame start is a
    // single clk pulse because it is cleared on every non-tick clk.
    always_comb begin
        h_coord_d = h_coord_q;
        v_coord_d = v_coord_q;
        disp_d    = disp_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        fs_d      = 1'b0;
        if (tick) begin
            h_coord_d = H_COORD_W'(h_cnt);
            v_coord_d = V_COORD_W'(v_cnt);
            disp_d    = h_vis & v_vis;
            hsync_d   = sync_level(h_sync, SYNC_POL);
            vsync_d   = sync_level(v_sync, SYNC_POL);
            fs_d      = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Output registers; all outputs share one edge for zero skew.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            h_coord_q <= '0;
            v_coord_q <= '0;
            disp_q    <= 1'b0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            fs_q      <= 1'b0;
        end else begin
            h_coord_q <= h_coord_d;
            v_coord_q <= v_coord_d;
            disp_q    <= disp_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            fs_q      <= fs_d;
        end
    end

    assign o_h_coord     = h_coord_q;
    assign o_v_coord     = v_coord_q;
    assign o_disp_enbl   = disp_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance plus a tiny active-low-sync
// instance so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } out_t;

    typedef struct {
        int   p;
        bit   rst;
        out_t e;
    } sb_t;

    typedef struct {
        string name;
        int    p;
        out_t  e;
    } vec_t;

    // Small timing: 15 x 10 raster, hsync h=10..12, vsync v=6..7, active low.
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 5, SVF = 1, SVS = 2, SVB = 2;
    localparam int S_FRAME = 150;
    localparam int NV = 12;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;

    logic [10:0] d_h, s_h;
    logic [9:0]  d_v, s_v;
    logic        d_de, d_hs, d_vs, d_fs;
    logic        s_de, s_hs, s_vs, s_fs;
    out_t        out_d, out_s;

    assign out_d = {d_h, d_v, d_de, d_hs, d_vs, d_fs};
    assign out_s = {s_h, s_v, s_de, s_hs, s_vs, s_fs};

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk           (clk),
        .arst_n        (arst_n),
        .o_h_coord     (d_h),
        .o_v_coord     (d_v),
        .o_disp_enbl   (d_de),
        .o_hsync       (d_hs),
        .o_vsync       (d_vs),
        .o_frame_start (d_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_POL  (1'b0)
    ) dut_s (
        .clk           (clk),
        .arst_n        (arst_n),
        .o_h_coord     (s_h),
        .o_v_coord     (s_v),
        .o_disp_enbl   (s_de),
        .o_hsync       (s_hs),
        .o_vsync       (s_vs),
        .o_frame_start (s_fs)
    );

    int   checks = 0;
    int   errors = 0;
    sb_t  q_d[$];
    sb_t  q_s[$];
    int   n_d = 0;
    int   n_s = 0;
    vec_t vecs[NV];

    function automatic out_t mk(int h, int v, bit de, bit hs, bit vs, bit fs);
        out_t o;
        o.h = 11'(h); o.v = 10'(v); o.de = de; o.hs = hs; o.vs = vs; o.fs = fs;
        return o;
    endfunction

    function automatic out_t rst_val(bit pol);
        return mk(0, 0, 1'b0, ~pol, ~pol, 1'b0);
    endfunction

    // Reference raster: position p ticks after reset release.
    function automatic out_t model(int p, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol);
        int ht, vt, h, v;
        bit hact, vact;
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        h    = p % ht;
        v    = (p / ht) % vt;
        hact = (h >= hv + hf) && (h < hv + hf + hsw);
        vact = (v >= vv + vf) && (v < vv + vf + vsw);
        return mk(h, v, (h < hv) && (v < vv), hact ? pol : ~pol,
                  vact ? pol : ~pol, (h == 0) && (v == 0));
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got h=%0d v=%0d de=%b hs=%b vs=%b fs=%b, want h=%0d v=%0d de=%b hs=%b vs=%b fs=%b",
                     name, $time, act.h, act.v, act.de, act.hs, act.vs, act.fs,
                     exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Scoreboard producer: one expected record per clk edge for each DUT.
    always @(posedge clk) begin : sb_push
        if (!arst_n) begin
            q_d.push_back('{p: -1, rst: 1'b1, e: rst_val(1'b1)});
            q_s.push_back('{p: -1, rst: 1'b1, e: rst_val(1'b0)});
            n_d <= 0;
            n_s <= 0;
        end else begin
            q_d.push_back('{p: n_d, rst: 1'b0,
                            e: model(n_d, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1)});
            q_s.push_back('{p: n_s, rst: 1'b0,
                            e: model(n_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0)});
            n_d <= n_d + 1;
            n_s <= n_s + 1;
        end
    end

    int cyc     = 0;
    int last_fs = -1;
    int vs_cnt  = 0;
    int de_cnt  = 0;

    // Scoreboard consumer plus per-frame measurements on the small raster.
    always @(negedge clk) begin : sb_pop
        sb_t sd, ss;
        if (q_d.size() > 0) begin
            sd = q_d.pop_front();
            check("sb_default", out_d, sd.e);
            if (!sd.rst) begin
                for (int i = 0; i < NV; i++) begin
                    if (vecs[i].p == sd.p) check(vecs[i].name, out_d, vecs[i].e);
                end
            end
        end
        if (q_s.size() > 0) begin
            ss = q_s.pop_front();
            check("sb_small", out_s, ss.e);
        end
        cyc++;
        if (!arst_n) begin
            last_fs = -1;
            vs_cnt  = 0;
            de_cnt  = 0;
        end else begin
            if (s_fs) begin
                if (last_fs >= 0) begin
                    check_int("frame_period", cyc - last_fs, S_FRAME);
                    check_int("vsync_clks", vs_cnt, SVS * (SHV + SHF + SHS + SHB));
                    check_int("disp_clks", de_cnt, SHV * SVV);
                end
                last_fs = cyc;
                vs_cnt  = 0;
                de_cnt  = 0;
            end
            if (s_vs == 1'b0) vs_cnt++;
            if (s_de) de_cnt++;
        end
    end

    initial begin
        int waited;
        vecs[0]  = '{"first_pixel", 0,    mk(0,    0, 1, 0, 0, 1)};
        vecs[1]  = '{"second_pix",  1,    mk(1,    0, 1, 0, 0, 0)};
        vecs[2]  = '{"last_vis",    799,  mk(799,  0, 1, 0, 0, 0)};
        vecs[3]  = '{"first_blank", 800,  mk(800,  0, 0, 0, 0, 0)};
        vecs[4]  = '{"pre_hsync",   855,  mk(855,  0, 0, 0, 0, 0)};
        vecs[5]  = '{"hsync_rise",  856,  mk(856,  0, 0, 1, 0, 0)};
        vecs[6]  = '{"hsync_last",  975,  mk(975,  0, 0, 1, 0, 0)};
        vecs[7]  = '{"hsync_fall",  976,  mk(976,  0, 0, 0, 0, 0)};
        vecs[8]  = '{"line_end",    1039, mk(1039, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"line1_start", 1040, mk(0,    1, 1, 0, 0, 0)};
        vecs[10] = '{"line1_pix1",  1041, mk(1,    1, 1, 0, 0, 0)};
        vecs[11] = '{"line3_hsync", 3*1040 + 900, mk(900, 3, 0, 1, 0, 0)};

        #1 arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_default", out_d, rst_val(1'b1));
        check("reset_small",   out_s, rst_val(1'b0));

        @(negedge clk);
        #2 arst_n = 1'b1;
        repeat (3200) @(negedge clk);

        // Mid-line asynchronous reset on the default raster at h=500.
        waited = 0;
        while (d_h != 11'd500 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_int("wait_h500", int'(d_h), 500);
        #2 arst_n = 1'b0;
        #1;
        check("async_rst_default", out_d, rst_val(1'b1));
        check("async_rst_small",   out_s, rst_val(1'b0));

        repeat (3) @(negedge clk);
        #2 arst_n = 1'b1;
        repeat (1200) @(negedge clk);

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
